// File: rtl/instr_fetch_reg_if.sv
// Fetch-stage bundle: instruction memory port, redirect input and the
// instruction-register outputs handed to the decode/extend stage.
interface instr_fetch_reg_if #(
  parameter int COUNT_W = 32
);
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ready;
  logic [31:0]        imem_rdata;
  logic               redirect_valid;
  logic [31:0]        redirect_target;
  logic               ir_valid;
  logic [31:0]        ir;
  logic [31:0]        ir_pc;
  logic [31:0]        ir_pc4;
  logic [15:0]        imm16;
  logic               ir_ack;
  logic               misalign;
  logic [COUNT_W-1:0] fetch_count;

  modport master (
    output imem_req, imem_addr, ir_valid, ir, ir_pc, ir_pc4, imm16,
           misalign, fetch_count,
    input  imem_ready, imem_rdata, redirect_valid, redirect_target, ir_ack
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, ir, ir_pc, ir_pc4, imm16,
           misalign, fetch_count,
    output imem_ready, imem_rdata, redirect_valid, redirect_target, ir_ack
  );
endinterface

// File: rtl/instr_fetch_reg.sv
// Instruction fetch stage: PC, req/ready fetch from instruction memory,
// instruction register held until acknowledged, redirect from execute.
module instr_fetch_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_fetch_reg_if.master bus
);

  // One-hot so imem_req and ir_valid come straight from state flops.
  localparam logic [2:0] ST_IDLE  = 3'b001;
  localparam logic [2:0] ST_FETCH = 3'b010;
  localparam logic [2:0] ST_HOLD  = 3'b100;

  logic [2:0]         state_r;
  logic [2:0]         state_nx_s;
  logic               fetch_fire_s;
  logic               imem_req_s;
  logic               ir_valid_s;
  logic [31:0]        pc_r;
  logic [31:0]        pc_plus4_s;
  logic [31:0]        ir_r;
  logic [31:0]        ir_pc_r;
  logic [31:0]        ir_pc4_r;
  logic               misalign_r;
  logic [COUNT_W-1:0] count_r;

  assign pc_plus4_s = pc_r + 32'd4;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; a redirect overrides every state.
  always_comb begin
    state_nx_s = state_r;
    if (bus.redirect_valid) begin
      state_nx_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_IDLE:  state_nx_s = ST_FETCH;
        ST_FETCH: state_nx_s = bus.imem_ready ? ST_HOLD : ST_FETCH;
        ST_HOLD:  state_nx_s = bus.ir_ack ? ST_FETCH : ST_HOLD;
        default:  state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Output decode; a returning word is dropped when a redirect coincides.
  always_comb begin
    imem_req_s   = 1'b0;
    ir_valid_s   = 1'b0;
    fetch_fire_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        imem_req_s = 1'b0;
      end
      ST_FETCH: begin
        imem_req_s   = 1'b1;
        fetch_fire_s = bus.imem_ready & ~bus.redirect_valid;
      end
      ST_HOLD: begin
        ir_valid_s = 1'b1;
      end
      default: begin
        imem_req_s = 1'b0;
      end
    endcase
  end

  // Program counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC & ~32'h0000_0003;
    end else if (bus.redirect_valid) begin
      pc_r <= bus.redirect_target & ~32'h0000_0003;
    end else if (fetch_fire_s) begin
      pc_r <= pc_plus4_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Instruction register with its PC and PC+4; kept intact across redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_r     <= 32'h0000_0000;
      ir_pc_r  <= 32'h0000_0000;
      ir_pc4_r <= 32'h0000_0000;
    end else if (fetch_fire_s) begin
      ir_r     <= bus.imem_rdata;
      ir_pc_r  <= pc_r;
      ir_pc4_r <= pc_plus4_s;
    end else begin
      ir_r     <= ir_r;
      ir_pc_r  <= ir_pc_r;
      ir_pc4_r <= ir_pc4_r;
    end
  end

  // Sticky misaligned-redirect flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_r <= 1'b0;
    end else if (bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00)) begin
      misalign_r <= 1'b1;
    end else begin
      misalign_r <= misalign_r;
    end
  end

  // Wrapping count of instructions latched into ir.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {COUNT_W{1'b0}};
    end else if (fetch_fire_s) begin
      count_r <= count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign bus.imem_req    = imem_req_s;
  assign bus.imem_addr   = pc_r;
  assign bus.ir_valid    = ir_valid_s;
  assign bus.ir          = ir_r;
  assign bus.ir_pc       = ir_pc_r;
  assign bus.ir_pc4      = ir_pc4_r;
  assign bus.imm16       = ir_r[15:0];
  assign bus.misalign    = misalign_r;
  assign bus.fetch_count = count_r;

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Directed self-checking bench for instr_fetch_reg: throughput, hold,
// memory stall, redirects (misaligned and wrapping) and async reset.
module tb_instr_fetch_reg;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  instr_fetch_reg_if #(.COUNT_W(32)) bus ();

  instr_fetch_reg #(.RESET_PC(32'h0000_0000), .COUNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset over one edge, release just after it; next edge leaves IDLE.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.imem_ready      = 1'b0;
    bus.imem_rdata      = 32'h0000_0000;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0000_0000;
    bus.ir_ack          = 1'b0;

    // Reset values
    tick();
    check_val("rst_req",   {31'd0, bus.imem_req}, 32'd0);
    check_val("rst_addr",  bus.imem_addr, 32'h0000_0000);
    check_val("rst_valid", {31'd0, bus.ir_valid}, 32'd0);
    check_val("rst_ir",    bus.ir, 32'd0);
    check_val("rst_pc4",   bus.ir_pc4, 32'd0);
    check_val("rst_mis",   {31'd0, bus.misalign}, 32'd0);
    check_val("rst_cnt",   bus.fetch_count, 32'd0);

    // Zero-wait memory, ack tied high: one fetch every 2 cycles
    bus.imem_ready = 1'b1;
    bus.ir_ack     = 1'b1;
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.imem_rdata = 32'h1000_0000 + 32'(k);
      check_val("tp_req",   {31'd0, bus.imem_req}, 32'd1);
      check_val("tp_addr",  bus.imem_addr, 32'(4 * k));
      check_val("tp_nvld",  {31'd0, bus.ir_valid}, 32'd0);
      tick();
      check_val("tp_vld",   {31'd0, bus.ir_valid}, 32'd1);
      check_val("tp_noreq", {31'd0, bus.imem_req}, 32'd0);
      check_val("tp_ir",    bus.ir, 32'h1000_0000 + 32'(k));
      check_val("tp_irpc",  bus.ir_pc, 32'(4 * k));
      check_val("tp_pc4",   bus.ir_pc4, 32'(4 * k + 4));
      check_val("tp_cnt",   bus.fetch_count, 32'(k + 1));
      tick();
    end

    // Hold without ack for 5 cycles
    bus.ir_ack = 1'b0;
    do_reset();
    bus.imem_rdata = 32'h2008_FFFC;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check_val("hold_vld",  {31'd0, bus.ir_valid}, 32'd1);
      check_val("hold_imm",  {16'd0, bus.imm16}, 32'h0000_FFFC);
      check_val("hold_req",  {31'd0, bus.imem_req}, 32'd0);
      check_val("hold_addr", bus.imem_addr, 32'h0000_0004);
      tick();
    end
    bus.ir_ack = 1'b1;
    tick();
    check_val("ack_req",  {31'd0, bus.imem_req}, 32'd1);
    check_val("ack_addr", bus.imem_addr, 32'h0000_0004);
    check_val("ack_vld",  {31'd0, bus.ir_valid}, 32'd0);

    // Memory stall of 3 cycles
    bus.imem_ready = 1'b0;
    do_reset();
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0BAD_F00D;
      end
      check_val("st_req",  {31'd0, bus.imem_req}, 32'd1);
      check_val("st_addr", bus.imem_addr, 32'h0000_0000);
      check_val("st_vld",  {31'd0, bus.ir_valid}, 32'd0);
      tick();
    end
    check_val("st_vld1", {31'd0, bus.ir_valid}, 32'd1);
    check_val("st_ir",   bus.ir, 32'h0BAD_F00D);
    check_val("st_cnt",  bus.fetch_count, 32'd1);

    // Misaligned redirect coincident with imem_ready
    tick();
    check_val("rd_pre_addr", bus.imem_addr, 32'h0000_0004);
    bus.imem_rdata      = 32'hDEAD_BEEF;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0103;
    tick();
    bus.redirect_valid = 1'b0;
    check_val("rd_addr", bus.imem_addr, 32'h0000_0100);
    check_val("rd_req",  {31'd0, bus.imem_req}, 32'd1);
    check_val("rd_vld",  {31'd0, bus.ir_valid}, 32'd0);
    check_val("rd_cnt",  bus.fetch_count, 32'd1);
    check_val("rd_ir",   bus.ir, 32'h0BAD_F00D);
    check_val("rd_mis",  {31'd0, bus.misalign}, 32'd1);
    bus.imem_rdata = 32'h1234_5678;
    tick();
    check_val("rd_irpc", bus.ir_pc, 32'h0000_0100);
    check_val("rd_pc4",  bus.ir_pc4, 32'h0000_0104);
    check_val("rd_cnt2", bus.fetch_count, 32'd2);

    // Redirect from HOLD to the top of the address space
    bus.ir_ack          = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    check_val("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
    check_val("wr_vld",  {31'd0, bus.ir_valid}, 32'd0);
    bus.imem_rdata = 32'h0000_0001;
    tick();
    check_val("wr_irpc", bus.ir_pc, 32'hFFFF_FFFC);
    check_val("wr_pc4",  bus.ir_pc4, 32'h0000_0000);
    check_val("wr_cnt",  bus.fetch_count, 32'd3);
    bus.ir_ack = 1'b1;
    tick();
    check_val("wr_next", bus.imem_addr, 32'h0000_0000);
    check_val("wr_mis",  {31'd0, bus.misalign}, 32'd1);

    // Asynchronous reset mid-HOLD
    bus.ir_ack = 1'b0;
    tick();
    check_val("ar_vld_pre", {31'd0, bus.ir_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_vld",  {31'd0, bus.ir_valid}, 32'd0);
    check_val("ar_req",  {31'd0, bus.imem_req}, 32'd0);
    check_val("ar_cnt",  bus.fetch_count, 32'd0);
    check_val("ar_mis",  {31'd0, bus.misalign}, 32'd0);
    check_val("ar_addr", bus.imem_addr, 32'h0000_0000);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("ar_req1",  {31'd0, bus.imem_req}, 32'd1);
    check_val("ar_addr1", bus.imem_addr, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_reg.md
Name: instr_fetch_reg

Overview:
- Instruction fetch stage with instruction register, directly upstream of the immediate sign-extension stage.
- Holds the PC and issues requests to instruction memory over a req/ready handshake.
- Latches the returned word into an instruction register and presents it, plus its PC, PC+4 and imm16 = ir[15:0], to the decode/extend stage.
- Holds each instruction until the consumer acknowledges it; accepts branch/jump redirects from the execute stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- COUNT_W, 32, width of the retired-fetch counter.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ready  in  1  memory has data on imem_rdata this cycle; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word; valid when imem_req&imem_ready.
- redirect_valid  in  1  one-cycle pulse: load new PC.
- redirect_target  in  32  new PC; bits [1:0] masked to 0.
- ir_valid  out  1  ir/ir_pc/ir_pc4/imm16 hold a valid instruction.
- ir  out  32  instruction register.
- ir_pc  out  32  address of the instruction in ir.
- ir_pc4  out  32  ir_pc + 4, modulo 2^32.
- imm16  out  16  ir[15:0], combinational from ir; feeds the sign extender.
- ir_ack  in  1  consumer has taken ir; sampled only while ir_valid=1.
- misalign  out  1  sticky: a redirect_target had nonzero bits [1:0].
- fetch_count  out  COUNT_W  number of instructions latched into ir, wrapping.

Behaviour:
- Reset values (rst_n=0, asynchronous): state=IDLE, pc=RESET_PC, imem_req=0, ir=0, ir_pc=0, ir_pc4=0, ir_valid=0, misalign=0, fetch_count=0.
- States are IDLE, FETCH and HOLD. imem_req=1 only in FETCH. ir_valid=1 only in HOLD; it is registered.
- IDLE: the first clock edge after rst_n rises moves to FETCH. imem_req first goes high one cycle after reset release.
- FETCH: imem_addr=pc, held stable until imem_ready. On an edge with imem_ready=1:
  - ir<=imem_rdata, ir_pc<=pc, ir_pc4<=pc+4, pc<=pc+4.
  - fetch_count<=fetch_count+1.
  - go to HOLD.
- FETCH latency: zero-wait memory gives ir_valid 1 cycle after the imem_req&imem_ready cycle.
- HOLD: ir and pc are frozen. On an edge with ir_ack=1, go to FETCH. The next request issues the following cycle, so peak throughput is 1 instruction per 2 cycles.
- Redirect has highest priority in every state. On an edge with redirect_valid=1:
  - pc<=redirect_target & ~32'h3; go to FETCH; ir_valid<=0.
  - A same-cycle imem_ready is discarded: no ir load, no count increment.
  - A same-cycle ir_ack is ignored.
  - ir contents are not cleared.
  - misalign<=1 if redirect_target[1:0]!=0. misalign clears only on reset.
  - Memory must tolerate abandonment of an unacknowledged request.
- Wrap rules: pc=32'hFFFF_FFFC advances to 0, and ir_pc4 likewise. fetch_count wraps from all-ones to 0.
- Reset asserted mid-FETCH or mid-HOLD: immediate return to reset values; the pending fetch is dropped.
- imem_rdata is not sampled when imem_ready=0. ir_ack is not sampled outside HOLD.

Test Plan:
- Reset release, memory ready every cycle, ir_ack tied 1 -> imem_addr sequence 0,4,8 every 2 cycles; ir_pc=0 with ir_pc4=4, then 4/8; fetch_count=3 after 3 fetches.
- imem_rdata=32'h2008_FFFC, hold ir_ack=0 for 5 cycles -> ir_valid stays 1, imm16=16'hFFFC, imem_req=0, pc frozen at 4; after ack, next imem_addr=4.
- Memory stalls 3 cycles (imem_ready=0) -> imem_addr stable at 0 and imem_req=1 for 4 cycles; ir_valid rises the cycle after ready.
- redirect_valid with target 32'h0000_0103 coincident with imem_ready in FETCH -> data discarded, fetch_count unchanged, next imem_addr=32'h100, misalign=1.
- Redirect to 32'hFFFF_FFFC, memory returns word -> ir_pc=32'hFFFF_FFFC, ir_pc4=0, next imem_addr=0.
- rst_n pulled low mid-HOLD with ir_valid=1 -> ir_valid, imem_req and fetch_count go to 0 immediately without a clock; after release imem_addr=RESET_PC.
